// File: rtl/hrmf_unscrambler.sv
// Radix-4 digit-reversed to natural-order reorder buffer with ping-pong frame banks.
// Optional start-of-frame resync (in_sof / err ports) is built when HRMF_UNSCR_SOF_EN is defined.
module hrmf_unscrambler #(
    parameter int LOG4N = 3
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_d0,
    input  logic [63:0] in_d1,
    input  logic [63:0] in_d2,
    input  logic [63:0] in_d3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_d0,
    output logic [63:0] out_d1,
    output logic [63:0] out_d2,
    output logic [63:0] out_d3,
    output logic        out_last
`ifdef HRMF_UNSCR_SOF_EN
    ,
    input  logic        in_sof,
    output logic        err
`endif
);

    localparam int N     = 4 ** LOG4N;
    localparam int BEATS = N / 4;
    localparam int AW    = 2 * LOG4N;
    localparam int BW    = AW - 2;

    logic [63:0]      mem_q [2][N];
    logic [3:0][63:0] in_lane, out_lane;

    logic [BW-1:0] wbeat_q, wbeat_d, rbeat_q, rbeat_d, wslot;
    logic          wb_q, wb_d, rb_q, rb_d;
    logic [1:0]    full_q, full_d;
    logic          wr_fire, rd_fire, wr_wrap, rd_wrap, resync;

    // Reverse the order of the base-4 digits of an index.
    function automatic logic [AW-1:0] digitrev4(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < LOG4N; i++) r[2*(LOG4N-1-i) +: 2] = k[2*i +: 2];
        return r;
    endfunction

    assign in_lane   = {in_d3, in_d2, in_d1, in_d0};
    assign in_ready  = ~full_q[wb_q];
    assign out_valid = full_q[rb_q];
    assign wr_fire   = in_valid & in_ready;
    assign rd_fire   = out_valid & out_ready;

`ifdef HRMF_UNSCR_SOF_EN
    logic err_q;
    // A mid-frame start marker restarts the current bank at beat 0.
    assign resync = wr_fire & in_sof & (wbeat_q != '0);
    assign err    = err_q;
`else
    assign resync = 1'b0;
`endif

    assign wslot    = resync ? '0 : wbeat_q;
    assign wr_wrap  = wr_fire & (wslot == BW'(BEATS - 1));
    assign rd_wrap  = rd_fire & (rbeat_q == BW'(BEATS - 1));
    assign out_last = out_valid & (rbeat_q == BW'(BEATS - 1));

    always_comb begin
        wbeat_d = wbeat_q;
        wb_d    = wb_q;
        rbeat_d = rbeat_q;
        rb_d    = rb_q;
        full_d  = full_q;
        if (wr_fire) wbeat_d = wslot + BW'(1);
        if (wr_wrap) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
        end
        if (rd_fire) rbeat_d = rbeat_q + BW'(1);
        // Never the same bank as a set above: the writer only targets a non-full bank.
        if (rd_wrap) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
        end
    end

    // Lane m of output beat o holds natural index 4*o+m.
    always_comb begin
        for (int m = 0; m < 4; m++) out_lane[m] = mem_q[rb_q][digitrev4({rbeat_q, 2'(m)})];
    end

    assign out_d0 = out_lane[0];
    assign out_d1 = out_lane[1];
    assign out_d2 = out_lane[2];
    assign out_d3 = out_lane[3];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < N; i++) mem_q[b][i] <= '0;
        end else if (wr_fire) begin
            for (int l = 0; l < 4; l++) mem_q[wb_q][{wslot, 2'(l)}] <= in_lane[l];
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wbeat_q <= '0;
            rbeat_q <= '0;
            wb_q    <= 1'b0;
            rb_q    <= 1'b0;
            full_q  <= '0;
        end else begin
            wbeat_q <= wbeat_d;
            rbeat_q <= rbeat_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            full_q  <= full_d;
        end
    end

`ifdef HRMF_UNSCR_SOF_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) err_q <= 1'b0;
        else       err_q <= resync;
    end
`endif

endmodule

// File: tb/tb_hrmf_unscrambler.sv
// Directed bench for hrmf_unscrambler: LOG4N=2 instance for reorder/flow-control cases,
// LOG4N=3 instance checked against an arithmetic digit-reversal model.
module tb_hrmf_unscrambler;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RSTn;

    logic             i2_valid, i2_ready, o2_valid, o2_ready, o2_last;
    logic [3:0][63:0] i2_d, o2_d;
    logic             i3_valid, i3_ready, o3_valid, o3_ready, o3_last;
    logic [3:0][63:0] i3_d, o3_d;
`ifdef HRMF_UNSCR_SOF_EN
    logic i2_sof, e2, i3_sof, e3;
`endif

    hrmf_unscrambler #(.LOG4N(2)) u2 (
        .CLK(CLK), .RSTn(RSTn), .in_valid(i2_valid), .in_ready(i2_ready),
        .in_d0(i2_d[0]), .in_d1(i2_d[1]), .in_d2(i2_d[2]), .in_d3(i2_d[3]),
        .out_valid(o2_valid), .out_ready(o2_ready),
        .out_d0(o2_d[0]), .out_d1(o2_d[1]), .out_d2(o2_d[2]), .out_d3(o2_d[3]),
        .out_last(o2_last)
`ifdef HRMF_UNSCR_SOF_EN
        , .in_sof(i2_sof), .err(e2)
`endif
    );

    hrmf_unscrambler #(.LOG4N(3)) u3 (
        .CLK(CLK), .RSTn(RSTn), .in_valid(i3_valid), .in_ready(i3_ready),
        .in_d0(i3_d[0]), .in_d1(i3_d[1]), .in_d2(i3_d[2]), .in_d3(i3_d[3]),
        .out_valid(o3_valid), .out_ready(o3_ready),
        .out_d0(o3_d[0]), .out_d1(o3_d[1]), .out_d2(o3_d[2]), .out_d3(o3_d[3]),
        .out_last(o3_last)
`ifdef HRMF_UNSCR_SOF_EN
        , .in_sof(i3_sof), .err(e3)
`endif
    );

    typedef struct packed { logic [3:0][63:0] d; logic sof;  } in_t;
    typedef struct packed { logic [3:0][63:0] d; logic last; } exp_t;

    int   total = 0, bad = 0;
    in_t  inq[$];
    exp_t expq[$];
    bit   want_rdy, rdy_s;
    int   cyc = 0, hs_cnt, hs_first, hs_last, stall_cnt, err_hi;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int drev(input int k, input int L);
        int r = 0;
        int v = k;
        for (int i = 0; i < L; i++) begin
            r = r * 4 + v % 4;
            v = v / 4;
        end
        return r;
    endfunction

    // Lane m of output beat o of a LOG4N=2 frame carries input position 4*m+o.
    task automatic push_frame(input int tag);
        in_t  x;
        exp_t e;
        for (int b = 0; b < 4; b++) begin
            x.sof = 1'b0;
            for (int l = 0; l < 4; l++) x.d[l] = {32'(tag), 32'(4*b+l)};
            inq.push_back(x);
        end
        for (int o = 0; o < 4; o++) begin
            for (int m = 0; m < 4; m++) e.d[m] = {32'(tag), 32'(4*m+o)};
            e.last = (o == 3);
            expq.push_back(e);
        end
    endtask

    // One cycle on u2: check the beat about to be taken, then present the next input beat.
    task automatic step2();
        exp_t e;
        @(negedge CLK);
        cyc++;
        o2_ready = want_rdy;
        rdy_s    = i2_ready;
`ifdef HRMF_UNSCR_SOF_EN
        if (e2) err_hi++;
`endif
        if (o2_valid && o2_ready) begin
            if (expq.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                e = expq.pop_front();
                chk("out_data", o2_d, e.d);
                chk("out_last", o2_last, e.last);
            end
            if (hs_cnt == 0) hs_first = cyc;
            hs_last = cyc;
            hs_cnt++;
        end
        if (inq.size() > 0) begin
            i2_valid = 1'b1;
            i2_d     = inq[0].d;
`ifdef HRMF_UNSCR_SOF_EN
            i2_sof   = inq[0].sof;
`endif
            if (i2_ready) void'(inq.pop_front());
            else stall_cnt++;
        end else begin
            i2_valid = 1'b0;
        end
    endtask

    task automatic run2(input int budget);
        for (int i = 0; i < budget && (inq.size() + expq.size()) > 0; i++) step2();
        step2();
        chk("drain_timeout", 32'(inq.size() + expq.size()), 0);
    endtask

    initial begin
        int   exp_p[4][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15}};
        exp_t tbl[4];
        in_t  held;
        logic [3:0][63:0] ev;

        RSTn = 1'b1; i2_valid = 1'b0; i2_d = '0; o2_ready = 1'b0;
        i3_valid = 1'b0; i3_d = '0; o3_ready = 1'b0; want_rdy = 1'b0;
`ifdef HRMF_UNSCR_SOF_EN
        i2_sof = 1'b0; i3_sof = 1'b0;
`endif
        #1 RSTn = 1'b0;
        #2;
        chk("rst_in_ready", i2_ready, 1);
        chk("rst_out_valid", o2_valid, 0);
        chk("rst_out_last", o2_last, 0);
        chk("rst_out_d", o2_d, 0);
        chk("rst3_out_valid", o3_valid, 0);
`ifdef HRMF_UNSCR_SOF_EN
        chk("rst_err", {e2, e3}, 0);
`endif
        @(negedge CLK) RSTn = 1'b1;

        // Basic reorder, table driven
        for (int o = 0; o < 4; o++) begin
            for (int m = 0; m < 4; m++) tbl[o].d[m] = {32'(exp_p[o][m]), 32'(exp_p[o][m])};
            tbl[o].last = (o == 3);
        end
        o2_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge CLK);
            chk("basic_not_valid", o2_valid, 0);
            chk("basic_in_ready", i2_ready, 1);
            i2_valid = 1'b1;
            for (int l = 0; l < 4; l++) i2_d[l] = {32'(4*b+l), 32'(4*b+l)};
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            i2_valid = 1'b0;
            chk($sformatf("basic_valid[%0d]", i), o2_valid, 1);
            chk($sformatf("basic_data[%0d]", i), o2_d, tbl[i].d);
            chk($sformatf("basic_last[%0d]", i), o2_last, tbl[i].last);
        end
        @(negedge CLK);
        chk("basic_drained", o2_valid, 0);

        // Streaming: four back-to-back frames
        want_rdy = 1'b1; hs_cnt = 0; stall_cnt = 0;
        for (int f = 1; f <= 4; f++) push_frame(f);
        run2(40);
        chk("stream_stalls", 32'(stall_cnt), 0);
        chk("stream_beats", 32'(hs_cnt), 16);
        chk("stream_contig", 32'(hs_last - hs_first), 15);

        // Backpressure: both banks fill, third frame waits
        want_rdy = 1'b0;
        push_frame(10); push_frame(11); push_frame(12);
        repeat (12) step2();
        chk("bp_pending", 32'(inq.size()), 4);
        chk("bp_in_ready", i2_ready, 0);
        chk("bp_out_valid", o2_valid, 1);
        want_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step2();
            chk($sformatf("bp_hold[%0d]", i), rdy_s, 0);
        end
        step2();
        chk("bp_release", rdy_s, 1);
        run2(30);

        // Reset during write beat 2 of the second frame
        want_rdy = 1'b0;
        push_frame(20); push_frame(21);
        repeat (6) step2();
        chk("pre_rst_valid", o2_valid, 1);
        @(negedge CLK);
        i2_valid = 1'b1;
        RSTn = 1'b0;
        #1;
        chk("midrst_out_valid", o2_valid, 0);
        chk("midrst_in_ready", i2_ready, 1);
        chk("midrst_out_last", o2_last, 0);
        inq.delete(); expq.delete();
        i2_valid = 1'b0;
        @(negedge CLK) RSTn = 1'b1;
        want_rdy = 1'b1;
        repeat (5) step2();
        chk("postrst_quiet", o2_valid, 0);
        push_frame(22);
        held = inq.pop_back();
        repeat (6) step2();
        chk("partial_quiet", o2_valid, 0);
        inq.push_back(held);
        run2(20);

`ifdef HRMF_UNSCR_SOF_EN
        // Resync: two beats of a stale frame, then a new frame starting with in_sof
        begin
            in_t g;
            err_hi = 0;
            for (int b = 0; b < 2; b++) begin
                g.sof = (b == 0);
                for (int l = 0; l < 4; l++) g.d[l] = {32'hBAD, 32'(4*b+l)};
                inq.push_back(g);
            end
            push_frame(7);
            inq[2].sof = 1'b1;
            run2(30);
            chk("sof_err_pulses", 32'(err_hi), 1);
            i2_sof = 1'b0;
        end
`endif

        // LOG4N=3 identity pattern against digit-reversal model
        for (int b = 0; b < 16; b++) begin
            @(negedge CLK);
            chk("l3_in_ready", i3_ready, 1);
            i3_valid = 1'b1;
            for (int l = 0; l < 4; l++) i3_d[l] = {32'h0, 32'(4*b+l)};
        end
        for (int o = 0; o < 16; o++) begin
            @(negedge CLK);
            i3_valid = 1'b0;
            o3_ready = 1'b1;
            for (int m = 0; m < 4; m++) ev[m] = {32'h0, 32'(drev(4*o+m, 3))};
            chk($sformatf("l3_valid[%0d]", o), o3_valid, 1);
            chk($sformatf("l3_data[%0d]", o), o3_d, ev);
            chk($sformatf("l3_last[%0d]", o), o3_last, (o == 15));
        end
        @(negedge CLK);
        chk("l3_drained", o3_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
